timer_controller: RTL

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_controller_if.sv | 29 ++
 rtl/timer_controller.sv | 99 +++++++++
 2 files changed

// File: rtl/timer_controller_if.sv
// Signal bundle between timer_controller, its requester and the countdown timer it drives.
// The slave modport is the controller; the master modport is its environment.
interface timer_controller_if #(
   parameter int unsigned N  = 8,
   parameter int unsigned PW = 8
);
   logic          start;
   logic          stop;
   logic [N-1:0]  period;
   logic [PW-1:0] prescale;
   logic          auto_reload;
   logic          load;
   logic [N-1:0]  value;
   logic          decr;
   logic          timeup;
   logic          busy;
   logic          expired;
   logic [N-1:0]  expire_count;

   modport slave (
      input  start, stop, period, prescale, auto_reload, timeup,
      output load, value, decr, busy, expired, expire_count
   );

   modport master (
      output start, stop, period, prescale, auto_reload, timeup,
      input  load, value, decr, busy, expired, expire_count
   );
endinterface

// File: rtl/timer_controller.sv
// Sequencer for an external countdown timer: loads it, paces its decrements through a
// prescaler, reports expiries and optionally reloads for periodic operation.
module timer_controller #(
   parameter int unsigned N  = 8,
   parameter int unsigned PW = 8
) (
   input logic               clk,
   input logic               reset,
   timer_controller_if.slave bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StRun  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  period_q, period_d;
   logic [PW-1:0] prescale_q, prescale_d;
   logic          ar_q, ar_d;
   logic [PW-1:0] pscnt_q, pscnt_d;
   logic [N-1:0]  count_q, count_d;

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      ar_d       = ar_q;
      pscnt_d    = pscnt_q;
      count_d    = count_q;
      case (state_q)
         StIdle: begin
            // A zero period would expire without ever counting, so it is not a valid start.
            if (bus.start && !bus.stop && (bus.period != '0)) begin
               period_d   = bus.period;
               prescale_d = bus.prescale;
               ar_d       = bus.auto_reload;
               count_d    = '0;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            pscnt_d = '0;
            state_d = bus.stop ? StIdle : StRun;
         end
         StRun: begin
            pscnt_d = (pscnt_q == prescale_q) ? '0 : pscnt_q + 1'b1;
            if (bus.stop) begin
               state_d = StIdle;
            end else if (bus.timeup) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // The expiry in this cycle is already committed; stop only cancels the reload.
            if (count_q != '1) begin
               count_d = count_q + 1'b1;
            end
            state_d = (ar_q && !bus.stop) ? StLoad : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         period_q   <= '0;
         prescale_q <= '0;
         ar_q       <= 1'b0;
         pscnt_q    <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         prescale_q <= prescale_d;
         ar_q       <= ar_d;
         pscnt_q    <= pscnt_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      bus.load         = (state_q == StLoad);
      bus.decr         = (state_q == StRun) && (pscnt_q == prescale_q) && !bus.timeup;
      bus.expired      = (state_q == StDone);
      bus.busy         = (state_q != StIdle);
      bus.value        = period_q;
      bus.expire_count = count_q;
   end

   strobes_exclusive_a : assert property (@(posedge clk) disable iff (!reset)
      $onehot0({bus.load, bus.decr, bus.expired}));

   capture_stable_a : assert property (@(posedge clk) disable iff (!reset)
      ((state_q != StIdle) && ($past(state_q) != StIdle)) |->
         ($stable(period_q) && $stable(prescale_q) && $stable(ar_q)));

endmodule
